// File: rtl/sd_resp_receiver.sv
// SD card CMD-line response receiver: waits for the start bit, shifts in a short or long
// frame on sample_en strobes, and checks CRC7, command index and framing bits.
module sd_resp_receiver #(
  parameter int SHORT_LEN = 48,
  parameter int LONG_LEN  = 136,
  parameter int NCR_MAX   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                start,
  input  logic [1:0]          resp_type,
  input  logic [5:0]          expected_idx,
  input  logic                sd_cmd,
  output logic                busy,
  output logic                started,
  output logic                done,
  output logic                crc_err,
  output logic                index_err,
  output logic                frame_err,
  output logic                timeout_err,
  output logic [LONG_LEN-1:0] response
);

  localparam int CW = $clog2(LONG_LEN + 1);
  localparam int NW = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, CHECK} state_t;

  state_t        state;
  logic [1:0]    type_q;
  logic [5:0]    idx_q;
  logic [CW-1:0] bit_cnt;
  logic [NW-1:0] ncr_cnt;
  logic [6:0]    crc;

  logic          is_long;
  logic [CW-1:0] frame_len;
  logic [CW-1:0] cnt_next;
  logic          crc_en;
  logic          crc_fb;
  logic [6:0]    crc_next;
  logic          crc_ok;
  logic          idx_ok;
  logic          tx_bit;

  always_comb begin
    is_long   = (type_q == 2'b10);
    frame_len = is_long ? CW'(LONG_LEN) : CW'(SHORT_LEN);
    cnt_next  = bit_cnt + 1'b1;
    // bit_cnt bits already received, so the incoming bit is frame bit LEN-1-bit_cnt;
    // long frames skip the 8-bit header, both stop before the CRC field.
    crc_en    = (bit_cnt <= frame_len - CW'(9)) && (!is_long || bit_cnt >= CW'(8));
    crc_fb    = sd_cmd ^ crc[6];
    crc_next  = {crc[5:0], crc_fb} ^ {3'b000, crc_fb, 3'b000};
    crc_ok    = (crc == response[7:1]);
    idx_ok    = (response[SHORT_LEN-3 -: 6] == idx_q);
    tx_bit    = is_long ? response[LONG_LEN-2] : response[SHORT_LEN-2];
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      type_q      <= 2'b00;
      idx_q       <= '0;
      bit_cnt     <= '0;
      ncr_cnt     <= '0;
      crc         <= '0;
      busy        <= 1'b0;
      started     <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      index_err   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      response    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            type_q      <= resp_type;
            idx_q       <= expected_idx;
            bit_cnt     <= '0;
            ncr_cnt     <= '0;
            crc         <= '0;
            crc_err     <= 1'b0;
            index_err   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            response    <= '0;
            busy        <= 1'b1;
            state       <= (resp_type == 2'b00) ? CHECK : WAIT_START;
          end
        end
        WAIT_START: begin
          if (sample_en) begin
            if (!sd_cmd) begin
              response <= {response[LONG_LEN-2:0], 1'b0};
              bit_cnt  <= CW'(1);
              crc      <= '0;
              started  <= 1'b1;
              state    <= RECEIVE;
            end else if (ncr_cnt == NW'(NCR_MAX - 1)) begin
              timeout_err <= 1'b1;
              state       <= CHECK;
            end else begin
              ncr_cnt <= ncr_cnt + 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (sample_en) begin
            response <= {response[LONG_LEN-2:0], sd_cmd};
            bit_cnt  <= cnt_next;
            if (crc_en) crc <= crc_next;
            if (cnt_next == frame_len) state <= CHECK;
          end
        end
        CHECK: begin
          // A timeout or a no-response command leaves the frame checks cleared.
          if (!timeout_err && type_q != 2'b00) begin
            crc_err   <= (type_q == 2'b01 || type_q == 2'b10) && !crc_ok;
            index_err <= (type_q == 2'b01) && !idx_ok;
            frame_err <= tx_bit || !response[0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          started <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Scoreboard bench for sd_resp_receiver: directed frames plus randomized traffic, expected
// results from a polynomial-division CRC7 reference and the frame-field rules.
module tb_sd_resp_receiver;

  localparam int SL = 48;
  localparam int LL = 136;
  localparam int NM = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_en = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    resp_type = 2'b00;
  logic [5:0]    expected_idx = 6'd0;
  logic          sd_cmd = 1'b1;
  logic          busy, started, done;
  logic          crc_err, index_err, frame_err, timeout_err;
  logic [LL-1:0] response;

  sd_resp_receiver #(.SHORT_LEN(SL), .LONG_LEN(LL), .NCR_MAX(NM)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .start(start),
    .resp_type(resp_type), .expected_idx(expected_idx), .sd_cmd(sd_cmd),
    .busy(busy), .started(started), .done(done),
    .crc_err(crc_err), .index_err(index_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .response(response)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LL-1:0] resp;
    logic          c, i, f, t;
    int            at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [LL-1:0] act, input logic [LL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [LL-1:0] f, input int hi);
    logic [LL+6:0] m;
    int n = hi - 7;
    m = '0;
    for (int i = 0; i < n; i++) m[i+7] = f[i+8];
    for (int k = n + 6; k >= 7; k--)
      if (m[k]) m[k -: 8] = m[k -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic exp_t model(input logic [1:0] typ, input logic [5:0] idx, input logic [LL-1:0] f);
    int   len = (typ == 2'b10) ? LL : SL;
    exp_t e;
    e.resp = f;
    e.t    = 1'b0;
    e.at   = 0;
    e.c    = (typ == 2'b01 || typ == 2'b10) && (crc7(f, (typ == 2'b10) ? LL - 9 : SL - 1) != f[7:1]);
    e.i    = (typ == 2'b01) && (f[SL-3 -: 6] != idx);
    e.f    = (f[len-2] != 1'b0) || (f[0] != 1'b1);
    return e;
  endfunction

  function automatic logic [LL-1:0] gen_frame(input logic [1:0] typ, input logic [5:0] idx);
    logic [LL-1:0] f;
    int len = (typ == 2'b10) ? LL : SL;
    f = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    if (typ != 2'b10) f[LL-1:SL] = '0;
    f[len-1] = 1'b0;
    f[len-2] = ($urandom_range(0, 7) == 0);
    if (typ == 2'b10) f[LL-3:LL-8] = 6'h3F;
    else if ($urandom_range(0, 3) != 0) f[SL-3 -: 6] = idx;
    f[7:1] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : crc7(f, (typ == 2'b10) ? LL - 9 : SL - 1);
    f[0] = ($urandom_range(0, 7) != 0);
    return f;
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("response", response, mon_e.resp);
        check("crc_err", crc_err, mon_e.c);
        check("index_err", index_err, mon_e.i);
        check("frame_err", frame_err, mon_e.f);
        check("timeout_err", timeout_err, mon_e.t);
        check("done_cycle", cyc, mon_e.at);
        check("idle_at_done", {busy, started}, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input bit junk);
    int gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      sample_en = 1'b0;
      sd_cmd    = 1'($urandom);
      if (junk && $urandom_range(0, 7) == 0) begin
        start     = 1'b1;
        resp_type = 2'($urandom);
      end
      tick();
      start = 1'b0;
    end
    sample_en = 1'b1;
    sd_cmd    = b;
    tick();
    sample_en = 1'b0;
    sd_cmd    = 1'($urandom);
  endtask

  task automatic arm(input logic [1:0] typ, input logic [5:0] idx);
    resp_type    = typ;
    expected_idx = idx;
    start        = 1'b1;
    sample_en    = 1'($urandom_range(0, 1));
    sd_cmd       = 1'b0;
    tick();
    start        = 1'b0;
    sample_en    = 1'b0;
    sd_cmd       = 1'b1;
    resp_type    = 2'($urandom);
    expected_idx = 6'($urandom);
    check("busy_after_start", busy, 1);
    check("flags_cleared", {crc_err, index_err, frame_err, timeout_err}, 0);
    check("response_cleared", response, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_released", busy, 0);
    tick();
  endtask

  task automatic send_frame(input logic [1:0] typ, input logic [5:0] idx, input logic [LL-1:0] frame,
                            input int idle_n, input int abort_at);
    int   len = (typ == 2'b10) ? LL : SL;
    exp_t e;
    arm(typ, idx);
    for (int k = 0; k < idle_n; k++) strobe(1'b1, 1'b1);
    check("started_before_start_bit", started, 0);
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        #3 reset = 1'b0;
        #1 check("reset_flags", {busy, started, done, crc_err, index_err, frame_err, timeout_err}, 0);
        check("reset_response", response, 0);
        #2 reset = 1'b1;
        return;
      end
      strobe(frame[len-1-k], 1'b1);
      if (k == 0) check("started_after_start_bit", started, 1);
    end
    e    = model(typ, idx, frame);
    e.at = cyc + 1;
    sb.push_back(e);
    wait_idle();
  endtask

  task automatic send_timeout(input logic [1:0] typ);
    exp_t e;
    arm(typ, 6'($urandom));
    for (int k = 1; k <= NM; k++) begin
      strobe(1'b1, 1'b1);
      if (k == NM - 1) check("busy_before_timeout", {busy, done}, 2'b10);
    end
    e.resp = '0;
    e.c = 1'b0; e.i = 1'b0; e.f = 1'b0; e.t = 1'b1;
    e.at = cyc + 1;
    sb.push_back(e);
    wait_idle();
  endtask

  task automatic send_none();
    exp_t e;
    arm(2'b00, 6'($urandom));
    e.resp = '0;
    e.c = 1'b0; e.i = 1'b0; e.f = 1'b0; e.t = 1'b0;
    e.at = cyc + 1;
    sb.push_back(e);
    wait_idle();
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LL-1:0] f;
    logic [LL-1:0] f2;
    int kind;
    logic [1:0] typ;
    logic [5:0] idx;

    repeat (3) tick();
    check("reset_state_flags", {busy, started, done, crc_err, index_err, frame_err, timeout_err}, 0);
    check("reset_state_response", response, 0);
    reset = 1'b1;

    f = LL'(48'h08_0000_01AA_13);
    send_frame(2'b01, 6'd8, f, 3, -1);
    send_frame(2'b01, 6'd8, LL'(48'h08_0000_01AA_12), 3, -1);
    send_frame(2'b01, 6'd9, f, 2, -1);
    send_frame(2'b11, 6'd0, LL'(48'h3F_80FF_8000_FF), 1, -1);
    send_frame(2'b11, 6'd0, LL'(48'h3F_80FF_8000_FE), 0, -1);

    f = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    f[LL-1:LL-8] = 8'h3F;
    f[7:1] = crc7(f, LL - 9);
    f[0] = 1'b1;
    send_frame(2'b10, 6'd0, f, 4, -1);
    f2 = f;
    f2[60] = ~f2[60];
    send_frame(2'b10, 6'd0, f2, 2, -1);

    send_timeout(2'b01);
    send_none();

    f = LL'(48'h08_0000_01AA_13);
    send_frame(2'b01, 6'd8, f, 2, 20);
    send_frame(2'b01, 6'd8, f, 1, -1);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) send_none();
      else if (kind == 1) send_timeout(2'($urandom_range(1, 3)));
      else begin
        typ = 2'($urandom_range(1, 3));
        idx = 6'($urandom);
        send_frame(typ, idx, gen_frame(typ, idx), $urandom_range(0, 8), -1);
      end
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_resp_receiver.md
SD_RESP_RECEIVER -- requirements
Module: sd_resp_receiver

Interface
REQ-001 The block SHALL have parameter SHORT_LEN, default 48, meaning the bit count of a short response frame (R1/R3/R6/R7).
REQ-002 The block SHALL have parameter LONG_LEN, default 136, meaning the bit count of a long response frame (R2).
REQ-003 The block SHALL have parameter NCR_MAX, default 64, meaning the number of sample strobes to wait for a start bit before timeout.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-cycle strobe marking each SD clock sampling point.
- start  in  1  pulse that arms the receiver.
- resp_type  in  2  00 none, 01 short with CRC, 10 long (R2), 11 short without CRC (R3).
- expected_idx  in  6  command index expected in a type-01 response.
- sd_cmd  in  1  serial CMD line.
- busy  out  1  high from accepted start until done.
- started  out  1  high from detected start bit until done.
- done  out  1  one-cycle completion pulse.
- crc_err, index_err, frame_err, timeout_err  out  1 each  status flags, valid with done and held until the next accepted start.
- response  out  LONG_LEN  received frame right-aligned; bit 0 is the end bit.

Function
REQ-005 States SHALL be IDLE, WAIT_START, RECEIVE and CHECK.
REQ-006 In IDLE, start=1 SHALL latch resp_type and expected_idx, clear all flags and response, and set busy.
- resp_type 00: next state CHECK.
- any other type: next state WAIT_START.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 sd_cmd SHALL be sampled only in cycles with sample_en=1, and no state other than CHECK SHALL advance without a strobe.
REQ-009 In WAIT_START, a sampled 0 SHALL be taken as the start bit.
- Shift the 0 in, set bit count to 1, set started, go to RECEIVE.
REQ-010 In WAIT_START, NCR_MAX consecutive sampled 1s SHALL set timeout_err and go to CHECK.
- Timeout occurs on the NCR_MAX-th strobe.
REQ-011 In RECEIVE, each strobe SHALL shift sd_cmd into response LSB and increment the bit count.
- The shift is MSB-first on the wire.
- When the count reaches the frame length (SHORT_LEN or LONG_LEN), go to CHECK.
REQ-012 CRC7 (x^7+x^3+1, register cleared at start-bit detection) SHALL be computed serially during RECEIVE, with no post-frame calculation latency.
- Short frame: covers frame bits [SHORT_LEN-1:8].
- Long frame: covers frame bits [LONG_LEN-9:8].
REQ-013 In CHECK (exactly one cycle), flags SHALL be set as follows, then done=1 and the block returns to IDLE with busy=0 and started=0:
- crc_err: CRC mismatch against received bits [7:1], types 01/10 only.
- index_err: frame bits [SHORT_LEN-3:SHORT_LEN-8] differ from expected_idx, type 01 only.
- frame_err: transmission bit (frame bit LEN-2) not 0, or end bit not 1.
REQ-014 On a timeout, crc_err, index_err and frame_err SHALL remain 0.
REQ-015 Latency: done SHALL assert exactly one clk after the clk edge that samples the last frame bit.
- For type 00, done asserts two clks after start.
REQ-016 For short frames, response[LONG_LEN-1:SHORT_LEN] SHALL be 0.
REQ-017 start and a strobe coinciding in IDLE SHALL only arm the block, and that strobe's sample SHALL be discarded.

Reset
REQ-018 reset=0 SHALL, asynchronously and at any time including mid-frame:
- force state IDLE;
- set busy, started, done and all flags to 0;
- set response, bit count, timeout count and CRC register to 0.
REQ-019 After reset releases, the block SHALL accept a start on the first clk edge.

Verification
REQ-020 Type 01, expected_idx=8, frame 0x08_0000_01AA_13 serialised after 3 idle strobes -> done with response=0x08000001AA13 and all flags 0.
REQ-021 Same frame with CRC byte 0x12 -> crc_err=1; with expected_idx=9 -> index_err=1 only.
REQ-022 Type 11, frame 0x3F_80FF_8000_FF -> done with crc_err=0 and frame_err=0; end bit forced to 0 -> frame_err=1.
REQ-023 Type 10, 136-bit frame with correct CRC7 over bits [127:8] -> done with crc_err=0 and response equal to the frame; one flipped payload bit -> crc_err=1.
REQ-024 sd_cmd held at 1 -> timeout_err=1 and done on the 64th strobe; start pulsed while busy -> no effect.
REQ-025 reset asserted at bit 20 of a frame -> all outputs 0 immediately; a subsequent valid frame is received correctly.
